// File: rtl/if_id_stage_buffer_if.sv
// Fetch-to-decode bundle for the IF/ID stage buffer.
// The master side is the fetch/decode environment and the slave side is the buffer.
interface if_id_stage_buffer_if #(
  parameter int INSTR_W = 20,
  parameter int PC_W    = 16,
  parameter int OP_W    = 4,
  parameter int DEPTH   = 2
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic [INSTR_W-1:0] instruction;
  logic [PC_W-1:0]    pc_in;
  logic               in_ready;
  logic               IF_ID_Hold;
  logic               flush;
  logic               out_ready;
  logic               out_valid;
  logic [INSTR_W-1:0] instructionPropagation;
  logic [PC_W-1:0]    pc_out;
  logic [OP_W-1:0]    opA;
  logic [OP_W-1:0]    opB;
  logic [OCC_W-1:0]   occupancy;

  modport master (
    output in_valid, instruction, pc_in, IF_ID_Hold, flush, out_ready,
    input  in_ready, out_valid, instructionPropagation, pc_out, opA, opB, occupancy
  );

  modport slave (
    input  in_valid, instruction, pc_in, IF_ID_Hold, flush, out_ready,
    output in_ready, out_valid, instructionPropagation, pc_out, opA, opB, occupancy
  );
endinterface

// File: rtl/if_id_stage_buffer.sv
// IF/ID pipeline stage: a DEPTH-entry FIFO of {instruction, pc} that lets fetch run ahead
// of a stalled decode, presenting the head entry and its opA/opB fields.
module if_id_stage_buffer #(
  parameter int                 INSTR_W   = 20,
  parameter int                 PC_W      = 16,
  parameter int                 OP_W      = 4,
  parameter int                 OPA_LSB   = 8,
  parameter int                 OPB_LSB   = 4,
  parameter int                 DEPTH     = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input logic                 clock,
  input logic                 reset,
  if_id_stage_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic               in_ready;
  logic               push;
  logic               pop;
  logic               head_valid;
  logic [INSTR_W-1:0] head_instr;
  logic [PC_W-1:0]    head_pc;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is a function of registered count, reset and flush only (never of in_valid);
  // a pop needs out_valid && out_ready with no decode hold. Full means not ready, even if
  // the head is being consumed in the same cycle.
  assign in_ready   = reset && (count < CNT_W'(DEPTH)) && !bus.flush;
  assign push       = bus.in_valid && in_ready;
  assign head_valid = (count != '0);
  assign pop        = head_valid && bus.out_ready && !bus.IF_ID_Hold;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= NOP_INSTR;
        pc_mem[i]    <= '0;
      end
    end else if (bus.flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= bus.instruction;
        pc_mem[wr_ptr]    <= bus.pc_in;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head is a mux over storage flops; an empty buffer shows the NOP so decode never sees stale data.
  assign head_instr = head_valid ? instr_mem[rd_ptr] : NOP_INSTR;
  assign head_pc    = head_valid ? pc_mem[rd_ptr]    : '0;

  assign bus.in_ready               = in_ready;
  assign bus.out_valid              = head_valid;
  assign bus.occupancy              = count;
  assign bus.instructionPropagation = head_instr;
  assign bus.pc_out                 = head_pc;
  assign bus.opA                    = head_instr[OPA_LSB +: OP_W];
  assign bus.opB                    = head_instr[OPB_LSB +: OP_W];
endmodule

// File: tb/tb_if_id_stage_buffer.sv
// Bench for if_id_stage_buffer: directed vectors on a default-parameter instance and
// randomised traffic on a DEPTH=4 / 32-bit instance, both checked against a queue model.
module tb_if_id_stage_buffer;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  if_id_stage_buffer_if #(.INSTR_W(20), .PC_W(16), .OP_W(4), .DEPTH(2)) bus_a ();
  if_id_stage_buffer_if #(.INSTR_W(32), .PC_W(16), .OP_W(5), .DEPTH(4)) bus_b ();

  if_id_stage_buffer #(
    .INSTR_W(20), .PC_W(16), .OP_W(4), .OPA_LSB(8), .OPB_LSB(4), .DEPTH(2), .NOP_INSTR(20'h0)
  ) dut_a (.clock(clock), .reset(reset), .bus(bus_a));

  if_id_stage_buffer #(
    .INSTR_W(32), .PC_W(16), .OP_W(5), .OPA_LSB(16), .OPB_LSB(12), .DEPTH(4), .NOP_INSTR(32'h0)
  ) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  // Expected entries, oldest first: {instruction zero-extended to 32 bits, pc}.
  logic [47:0] exp_qa[$];
  logic [47:0] exp_qb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT state against the model, then applies the coming edge to the model.
  always @(negedge clock) begin : monitor
    logic [47:0] ha, hb;
    logic        rdy_a, rdy_b, pop_a, pop_b;
    if (!reset) begin
      exp_qa.delete();
      exp_qb.delete();
    end
    ha = (exp_qa.size() != 0) ? exp_qa[0] : 48'h0;
    hb = (exp_qb.size() != 0) ? exp_qb[0] : 48'h0;
    rdy_a = reset && (exp_qa.size() < 2) && !bus_a.flush;
    rdy_b = reset && (exp_qb.size() < 4) && !bus_b.flush;

    chk("a_in_ready",  32'(bus_a.in_ready),  32'(rdy_a));
    chk("a_out_valid", 32'(bus_a.out_valid), 32'(exp_qa.size() != 0));
    chk("a_occupancy", 32'(bus_a.occupancy), exp_qa.size());
    chk("a_instr",     32'(bus_a.instructionPropagation), ha[47:16]);
    chk("a_pc",        32'(bus_a.pc_out), 32'(ha[15:0]));
    chk("a_opA",       32'(bus_a.opA), 32'(ha[27:24]));
    chk("a_opB",       32'(bus_a.opB), 32'(ha[23:20]));

    chk("b_in_ready",  32'(bus_b.in_ready),  32'(rdy_b));
    chk("b_out_valid", 32'(bus_b.out_valid), 32'(exp_qb.size() != 0));
    chk("b_occupancy", 32'(bus_b.occupancy), exp_qb.size());
    chk("b_instr",     bus_b.instructionPropagation, hb[47:16]);
    chk("b_pc",        32'(bus_b.pc_out), 32'(hb[15:0]));
    chk("b_opA",       32'(bus_b.opA), 32'(hb[36:32]));
    chk("b_opB",       32'(bus_b.opB), 32'(hb[32:28]));

    if (reset) begin
      pop_a = (exp_qa.size() != 0) && bus_a.out_ready && !bus_a.IF_ID_Hold;
      if (bus_a.flush) exp_qa.delete();
      else begin
        if (pop_a) void'(exp_qa.pop_front());
        if (bus_a.in_valid && rdy_a) exp_qa.push_back({12'h0, bus_a.instruction, bus_a.pc_in});
      end
      pop_b = (exp_qb.size() != 0) && bus_b.out_ready && !bus_b.IF_ID_Hold;
      if (bus_b.flush) exp_qb.delete();
      else begin
        if (pop_b) void'(exp_qb.pop_front());
        if (bus_b.in_valid && rdy_b) exp_qb.push_back({bus_b.instruction, bus_b.pc_in});
      end
    end
  end

  // Each driver call holds its inputs for exactly one rising edge.
  task automatic drive_a(input logic v, input logic [19:0] ins, input logic [15:0] pc,
                         input logic ordy, input logic hold, input logic fl);
    bus_a.in_valid    = v;
    bus_a.instruction = ins;
    bus_a.pc_in       = pc;
    bus_a.out_ready   = ordy;
    bus_a.IF_ID_Hold  = hold;
    bus_a.flush       = fl;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] ins, input logic [15:0] pc,
                         input logic ordy, input logic hold, input logic fl);
    bus_b.in_valid    = v;
    bus_b.instruction = ins;
    bus_b.pc_in       = pc;
    bus_b.out_ready   = ordy;
    bus_b.IF_ID_Hold  = hold;
    bus_b.flush       = fl;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.instruction = '0; bus_a.pc_in = '0;
    bus_a.out_ready = 1'b0; bus_a.IF_ID_Hold = 1'b0; bus_a.flush = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.instruction = '0; bus_b.pc_in = '0;
    bus_b.out_ready = 1'b0; bus_b.IF_ID_Hold = 1'b0; bus_b.flush = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Fill both entries, then hit reset between edges.
    drive_a(1'b1, 20'h11111, 16'h0100, 1'b0, 1'b0, 1'b0);
    drive_a(1'b1, 20'h22222, 16'h0104, 1'b0, 1'b0, 1'b0);
    drive_a(1'b0, 20'h0,     16'h0,    1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // First push after reset: opA = bits [11:8] = 0xC, opB = bits [7:4] = 0xD.
    drive_a(1'b1, 20'hABCDE, 16'h0200, 1'b0, 1'b0, 1'b0);
    drive_a(1'b0, 20'h0,     16'h0,    1'b0, 1'b0, 1'b0);
    drive_a(1'b0, 20'h0,     16'h0,    1'b1, 1'b0, 1'b0);

    // Back-to-back stream with a 3-cycle decode hold in the middle; the cycle after the
    // hold is a full buffer with a simultaneous pop.
    for (int i = 1; i <= 16; i++) begin
      drive_a(1'b1, 20'(i), 16'(16'h1000 + 4 * i), 1'b1, (i >= 6 && i <= 8), 1'b0);
    end
    drive_a(1'b0, 20'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    drive_a(1'b0, 20'h0, 16'h0, 1'b1, 1'b0, 1'b0);

    // Flush a full buffer under hold with an incoming instruction, then resume.
    drive_a(1'b1, 20'h33333, 16'h0300, 1'b0, 1'b0, 1'b0);
    drive_a(1'b1, 20'h44444, 16'h0304, 1'b0, 1'b0, 1'b0);
    drive_a(1'b1, 20'h55555, 16'h0308, 1'b1, 1'b1, 1'b1);
    drive_a(1'b1, 20'h66666, 16'h030C, 1'b0, 1'b0, 1'b0);
    drive_a(1'b0, 20'h0,     16'h0,    1'b1, 1'b0, 1'b0);
    drive_a(1'b0, 20'h0,     16'h0,    1'b1, 1'b0, 1'b0);

    // Wide, deep instance: random push/pop/hold/flush traffic.
    for (int i = 0; i < 800; i++) begin
      drive_b($urandom_range(0, 3) != 0, $urandom, 16'($urandom_range(0, 65535)),
              $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);
    end
    repeat (6) drive_b(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
